// File: rtl/fir_xifu_lsu_ctrl_if.sv
// rtl/fir_xifu_lsu_ctrl_if.sv - EX request, commit, xif_mem, mem_result and WB signal bundle
interface fir_xifu_lsu_ctrl_if #(
    parameter int ID_W = 4
);
    logic            req_valid_i;
    logic            req_we_i;
    logic [ID_W-1:0] req_id_i;
    logic [31:0]     req_addr_i;
    logic [31:0]     req_wdata_i;
    logic            ready_o;

    logic            commit_valid_i;
    logic [ID_W-1:0] commit_id_i;
    logic            commit_kill_i;

    logic            mem_valid_o;
    logic            mem_ready_i;
    logic [ID_W-1:0] mem_id_o;
    logic [31:0]     mem_addr_o;
    logic            mem_we_o;
    logic [31:0]     mem_wdata_o;

    logic            mem_result_valid_i;
    logic [ID_W-1:0] mem_result_id_i;
    logic [31:0]     mem_result_rdata_i;

    logic            wb_valid_o;
    logic [ID_W-1:0] wb_id_o;
    logic [31:0]     wb_rdata_o;

    modport master (
        output req_valid_i, req_we_i, req_id_i, req_addr_i, req_wdata_i,
        input  ready_o,
        output commit_valid_i, commit_id_i, commit_kill_i,
        input  mem_valid_o, mem_id_o, mem_addr_o, mem_we_o, mem_wdata_o,
        output mem_ready_i,
        output mem_result_valid_i, mem_result_id_i, mem_result_rdata_i,
        input  wb_valid_o, wb_id_o, wb_rdata_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_id_i, req_addr_i, req_wdata_i,
        output ready_o,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        output mem_valid_o, mem_id_o, mem_addr_o, mem_we_o, mem_wdata_o,
        input  mem_ready_i,
        input  mem_result_valid_i, mem_result_id_i, mem_result_rdata_i,
        output wb_valid_o, wb_id_o, wb_rdata_o
    );
endinterface

// File: rtl/fir_xifu_lsu_ctrl.sv
// rtl/fir_xifu_lsu_ctrl.sv - FIR XIFU load/store sequencer toward the CV32E40X memory interface
module fir_xifu_lsu_ctrl #(
    parameter int ID_W            = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    fir_xifu_lsu_ctrl_if.slave   bus,
    output logic                 killed_o,
    output logic                 err_o
);
    localparam int NUM_ID = 2 ** ID_W;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, WAIT_COMMIT, REQ} state_t;

    state_t              state, state_d;
    logic [NUM_ID-1:0]   bitmap, bitmap_d;
    logic [CNT_W-1:0]    outstanding;
    logic [ID_W-1:0]     lat_id;
    logic [31:0]         lat_addr;
    logic                lat_we;
    logic [31:0]         lat_wdata;
    logic                wb_valid;
    logic [ID_W-1:0]     wb_id;
    logic [31:0]         wb_rdata;

    logic ready, mem_valid, accept, issue, go_wait, kill_ev;
    logic commit_set, resp, resp_ok, clr_bit;

    assign commit_set = bus.commit_valid_i & ~bus.commit_kill_i;
    assign resp       = bus.mem_result_valid_i;
    assign resp_ok    = resp & (outstanding != '0);
    assign clr_bit    = (issue & lat_we) | kill_ev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (!bus.req_we_i || bitmap[bus.req_id_i] ||
                        (commit_set && bus.commit_id_i == bus.req_id_i))
                        state_d = REQ;
                    else
                        state_d = WAIT_COMMIT;
                end
                WAIT_COMMIT: begin
                    if (go_wait)      state_d = REQ;
                    else if (kill_ev) state_d = IDLE;
                end
                REQ:     if (bus.mem_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ready     = (state == IDLE) && (outstanding < MAX_CNT);
        mem_valid = (state == REQ);
        accept    = bus.req_valid_i & ready;
        issue     = mem_valid & bus.mem_ready_i;
        go_wait   = (commit_set && bus.commit_id_i == lat_id) || bitmap[lat_id];
        kill_ev   = (state == WAIT_COMMIT) && !go_wait && bus.commit_valid_i &&
                    bus.commit_kill_i && (bus.commit_id_i == lat_id) && !clear_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_id    <= '0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_id    <= bus.req_id_i;
            lat_addr  <= bus.req_addr_i;
            lat_we    <= bus.req_we_i;
            lat_wdata <= bus.req_wdata_i;
        end
    end

    // A clear of the latched store's bit beats a new commit only when both hit the same id
    always_comb begin
        bitmap_d = bitmap;
        if (clr_bit) bitmap_d[lat_id] = 1'b0;
        if (commit_set && !(clr_bit && bus.commit_id_i == lat_id))
            bitmap_d[bus.commit_id_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      bitmap <= '0;
        else if (clear_i) bitmap <= '0;
        else              bitmap <= bitmap_d;
    end

    // Not flushed by clear_i: responses to already accepted requests still come back
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
        end else if (issue && !resp_ok) begin
            outstanding <= outstanding + 1'b1;
        end else if (!issue && resp_ok) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid <= 1'b0;
            wb_id    <= '0;
            wb_rdata <= '0;
            killed_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            wb_valid <= resp;
            if (resp) begin
                wb_id    <= bus.mem_result_id_i;
                wb_rdata <= bus.mem_result_rdata_i;
            end
            killed_o <= kill_ev;
            err_o    <= resp && (outstanding == '0);
        end
    end

    assign bus.ready_o     = ready;
    assign bus.mem_valid_o = mem_valid;
    assign bus.mem_id_o    = lat_id;
    assign bus.mem_addr_o  = lat_addr;
    assign bus.mem_we_o    = lat_we;
    assign bus.mem_wdata_o = lat_wdata;
    assign bus.wb_valid_o  = wb_valid;
    assign bus.wb_id_o     = wb_id;
    assign bus.wb_rdata_o  = wb_rdata;
endmodule

// File: tb/tb_fir_xifu_lsu_ctrl.sv
// tb/tb_fir_xifu_lsu_ctrl.sv - randomized reference-model bench for fir_xifu_lsu_ctrl
module tb_fir_xifu_lsu_ctrl;
    localparam int ID_W = 4;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic killed, err;
    int   checks = 0;
    int   failures = 0;

    fir_xifu_lsu_ctrl_if #(.ID_W(ID_W)) bus ();

    fir_xifu_lsu_ctrl #(.ID_W(ID_W), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clear_i  (clear),
        .bus      (bus),
        .killed_o (killed),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rv; bit we; bit [3:0] id; bit [31:0] addr; bit [31:0] wdata;
        bit cv; bit ck; bit [3:0] cid;
        bit mr;
        bit resv; bit [3:0] resid; bit [31:0] resd;
        bit clr;
    } stim_t;

    // Reference model: one pending instruction, set of committed ids, in-flight count
    bit        m_have, m_go, m_we;
    bit [3:0]  m_id;
    bit [31:0] m_addr, m_wdata;
    int        m_out;
    bit        m_commit [16];
    bit        m_wbv, m_killed, m_err;
    bit [3:0]  m_wbid;
    bit [31:0] m_wbd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_go = 0; m_we = 0; m_id = 0; m_addr = 0; m_wdata = 0;
        m_out = 0; m_wbv = 0; m_killed = 0; m_err = 0; m_wbid = 0; m_wbd = 0;
        for (int i = 0; i < 16; i++) m_commit[i] = 0;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.mr = 1;
        return s;
    endfunction

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = m_have && m_go;
        check("ready", bus.ready_o, (!m_have && m_out < MAXO));
        check("mem_valid", bus.mem_valid_o, exp_valid);
        if (exp_valid) begin
            check("mem_id", bus.mem_id_o, m_id);
            check("mem_addr", bus.mem_addr_o, m_addr);
            check("mem_we", bus.mem_we_o, m_we);
            check("mem_wdata", bus.mem_wdata_o, m_wdata);
        end
        check("wb_valid", bus.wb_valid_o, m_wbv);
        check("wb_id", bus.wb_id_o, m_wbid);
        check("wb_rdata", bus.wb_rdata_o, m_wbd);
        check("killed", killed, m_killed);
        check("err", err, m_err);
    endtask

    task automatic step(input stim_t s);
        bit ready_e, commit_set, hs, kill_ev, clr_id;
        bit [3:0] old_id;
        @(negedge clk);
        check_outputs();
        bus.req_valid_i = s.rv; bus.req_we_i = s.we; bus.req_id_i = s.id;
        bus.req_addr_i = s.addr; bus.req_wdata_i = s.wdata;
        bus.commit_valid_i = s.cv; bus.commit_kill_i = s.ck; bus.commit_id_i = s.cid;
        bus.mem_ready_i = s.mr;
        bus.mem_result_valid_i = s.resv; bus.mem_result_id_i = s.resid;
        bus.mem_result_rdata_i = s.resd;
        clear = s.clr;

        ready_e    = !m_have && m_out < MAXO;
        commit_set = s.cv && !s.ck;
        hs         = m_have && m_go && s.mr;
        kill_ev    = m_have && !m_go && s.cv && s.ck && s.cid == m_id &&
                     !m_commit[m_id] && !s.clr;
        clr_id     = (hs && m_we) || kill_ev;
        old_id     = m_id;

        m_killed = kill_ev;
        m_err    = s.resv && m_out == 0;
        m_wbv    = s.resv;
        if (s.resv) begin m_wbid = s.resid; m_wbd = s.resd; end
        if (hs && !(s.resv && m_out > 0)) m_out++;
        else if (!hs && s.resv && m_out > 0) m_out--;

        if (s.clr || hs || kill_ev) begin
            m_have = 0;
        end else if (m_have && !m_go) begin
            if ((commit_set && s.cid == m_id) || m_commit[m_id]) m_go = 1;
        end else if (!m_have && s.rv && ready_e) begin
            m_have = 1; m_we = s.we; m_id = s.id; m_addr = s.addr; m_wdata = s.wdata;
            m_go = !s.we || m_commit[s.id] || (commit_set && s.cid == s.id);
        end

        if (s.clr) begin
            for (int i = 0; i < 16; i++) m_commit[i] = 0;
        end else begin
            if (clr_id) m_commit[old_id] = 0;
            if (commit_set && !(clr_id && s.cid == old_id)) m_commit[s.cid] = 1;
        end
    endtask

    task automatic drive_idle();
        stim_t s;
        s = idle();
        bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_id_i = 0; bus.req_addr_i = 0;
        bus.req_wdata_i = 0; bus.commit_valid_i = 0; bus.commit_kill_i = 0;
        bus.commit_id_i = 0; bus.mem_ready_i = s.mr; bus.mem_result_valid_i = 0;
        bus.mem_result_id_i = 0; bus.mem_result_rdata_i = 0; clear = 0;
    endtask

    initial begin
        stim_t s;
        model_reset();
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_mem_valid", bus.mem_valid_o, 0);
        check("rst_wb_valid", bus.wb_valid_o, 0);
        check("rst_wb_rdata", bus.wb_rdata_o, 0);
        check("rst_killed", killed, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // Load id 3 at 0x1000, response returns later
        s = idle(); s.rv = 1; s.id = 3; s.addr = 32'h1000; step(s);
        settle();
        check("tp_load_valid", bus.mem_valid_o, 1);
        check("tp_load_addr", bus.mem_addr_o, 32'h1000);
        check("tp_load_we", bus.mem_we_o, 0);
        step(idle()); step(idle());
        s = idle(); s.resv = 1; s.resid = 3; s.resd = 32'hCAFEBABE; step(s);
        settle();
        check("tp_load_wb_valid", bus.wb_valid_o, 1);
        check("tp_load_wb_rdata", bus.wb_rdata_o, 32'hCAFEBABE);

        // Store id 5 waits for its commit
        s = idle(); s.rv = 1; s.we = 1; s.id = 5; s.addr = 32'h2000; s.wdata = 32'h12345678;
        step(s);
        step(idle()); step(idle());
        settle();
        check("tp_store_wait_valid", bus.mem_valid_o, 0);
        check("tp_store_wait_ready", bus.ready_o, 0);
        s = idle(); s.cv = 1; s.cid = 5; step(s);
        settle();
        check("tp_store_valid", bus.mem_valid_o, 1);
        check("tp_store_we", bus.mem_we_o, 1);
        check("tp_store_wdata", bus.mem_wdata_o, 32'h12345678);
        step(idle());
        s = idle(); s.resv = 1; s.resid = 5; step(s);

        // Store id 6 killed
        s = idle(); s.rv = 1; s.we = 1; s.id = 6; step(s);
        step(idle());
        s = idle(); s.cv = 1; s.ck = 1; s.cid = 6; step(s);
        settle();
        check("tp_kill_pulse", killed, 1);
        check("tp_kill_valid", bus.mem_valid_o, 0);
        step(idle());
        settle();
        check("tp_kill_pulse_end", killed, 0);
        check("tp_kill_ready", bus.ready_o, 1);

        // Clear while the request is stalled by mem_ready_i
        s = idle(); s.rv = 1; s.id = 1; s.mr = 0; step(s);
        s = idle(); s.mr = 0; step(s);
        s.clr = 1; step(s);
        settle();
        check("tp_clear_valid", bus.mem_valid_o, 0);
        check("tp_clear_ready", bus.ready_o, 1);
        s = idle(); s.mr = 0; step(s);

        // Response with nothing outstanding
        s = idle(); s.resv = 1; s.resd = 32'h0BAD0BAD; step(s);
        settle();
        check("tp_err_pulse", err, 1);

        for (int n = 0; n < 2500; n++) begin
            s = idle();
            s.mr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                s.rv = 1; s.we = 1'($urandom_range(0, 1)); s.id = 4'($urandom_range(0, 15));
                s.addr = $urandom; s.wdata = $urandom;
            end
            if ($urandom_range(0, 9) < 4) begin
                s.cv = 1;
                s.ck = ($urandom_range(0, 4) == 0);
                s.cid = (m_have && !m_go && $urandom_range(0, 1)) ? m_id : 4'($urandom_range(0, 15));
            end
            if ((m_out > 0 && $urandom_range(0, 99) < 35) || $urandom_range(0, 99) == 0) begin
                s.resv = 1; s.resid = 4'($urandom_range(0, 15)); s.resd = $urandom;
            end
            s.clr = ($urandom_range(0, 49) == 0);
            step(s);
        end

        // Asynchronous reset mid-transaction, then a late response
        s = idle(); s.rv = 1; s.id = 2; s.mr = 0; step(s);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mem_valid", bus.mem_valid_o, 0);
        check("async_rst_wb_valid", bus.wb_valid_o, 0);
        check("async_rst_err", err, 0);
        model_reset();
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        s = idle(); s.resv = 1; s.resid = 2; s.resd = 32'h5A5A5A5A; step(s);
        settle();
        check("late_resp_err", err, 1);
        step(idle());
        step(idle());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
